// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader for the CPU instruction memory
`timescale 1ns/1ps

module instr_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic        cpu_rst_n_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Word count is compared as a 32-bit unsigned quantity to keep widths explicit.
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam int          APAD_W  = 32 - CNT_W - 2;

    state_t             state_q, state_d;
    logic [7:0]         hdr_hi_q, hdr_hi_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [23:0]        shift_q, shift_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;

    logic               xfer;
    logic [15:0]        hdr_full;
    logic               last_word;

    assign xfer      = rx_valid_i & ready_q;
    assign hdr_full  = {hdr_hi_q, rx_data_i};
    assign last_word = (wcnt_q == (n_q - {{(CNT_W-1){1'b0}}, 1'b1}));

    // Next-state and registered-output decode; all outputs default to holding.
    always_comb begin
        state_d     = state_q;
        hdr_hi_d    = hdr_hi_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        err_d       = err_q;
        cpu_rst_n_d = cpu_rst_n_q;
        ready_d     = 1'b0;

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    hdr_hi_d = rx_data_i;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    n_d    = CNT_W'(hdr_full);
                    wcnt_d = '0;
                    bcnt_d = 2'd0;
                    if (hdr_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({16'd0, hdr_full} > DEPTH_U) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], rx_data_i};
                    if (bcnt_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = {{APAD_W{1'b0}}, wcnt_q, 2'b00};
                        data_d = {shift_q, rx_data_i};
                        wcnt_d = wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (last_word) begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                // Lets the final write pulse retire before the CPU is released.
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d      = 1'b1;
                cpu_rst_n_d = 1'b1;
            end
            S_ERR: begin
                err_d       = 1'b1;
                cpu_rst_n_d = 1'b0;
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase

        // Ready is a pure function of the state being entered.
        ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_LEN_HI;
            hdr_hi_q    <= 8'd0;
            n_q         <= '0;
            wcnt_q      <= '0;
            bcnt_q      <= 2'd0;
            shift_q     <= 24'd0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_hi_q    <= hdr_hi_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign rx_ready_o  = ready_q;
    assign im_we_o     = we_q;
    assign im_addr_o   = addr_q;
    assign im_data_o   = data_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
`timescale 1ns/1ps

module tb_instr_loader;

    localparam int DEPTH = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_o;
    logic        cpu_rst_n_o;
    logic        done_o;
    logic        err_o;

    instr_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .im_we_o     (im_we_o),
        .im_addr_o   (im_addr_o),
        .im_data_o   (im_data_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          last_we_cyc = 0;
    logic [31:0] last_addr = 32'd0;
    int          first_xfer_cyc = 0;
    int          last_xfer_cyc = 0;
    logic [7:0]  stream[$];
    wr_t         exp_q[$];
    wr_t         cur;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write pulse is matched against the next expected (addr, data) pair.
    always @(negedge clk_i) begin
        if (im_we_o) begin
            wr_count++;
            last_we_cyc = cyc;
            last_addr = im_addr_o;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                check("wr_addr", im_addr_o, cur.addr);
                check("wr_data", im_data_o, cur.data);
            end
        end
        if (rst_i) begin
            check("cpu_rst_tracks_done", {31'd0, cpu_rst_n_o}, {31'd0, done_o});
        end
    end

    // Model: header is big-endian N; legal N yields N big-endian words at 4*k.
    task automatic model_expect();
        int n;
        wr_t w;
        n = {stream[0], stream[1]};
        if (n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                if (2 + 4*k + 3 < stream.size()) begin
                    w.addr = 32'(4*k);
                    w.data = {stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]};
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int tries;
        bit sent;
        tries = 0;
        sent = 0;
        while (!sent) begin
            @(negedge clk_i);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                rx_valid_i = 1'b0;
            end else begin
                rx_valid_i = 1'b1;
                rx_data_i = b;
                if (rx_ready_o) begin
                    last_xfer_cyc = cyc + 1;
                    sent = 1;
                end
            end
            tries++;
            if (!sent && tries > 300) begin
                check("ready_timeout", 32'd0, 32'd1);
                sent = 1;
            end
        end
    endtask

    task automatic send_stream(input int gap_pct);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], gap_pct);
            if (i == 0) first_xfer_cyc = last_xfer_cyc;
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        rx_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", {31'd0, rx_ready_o}, 32'd0);
        check("rst_we", {31'd0, im_we_o}, 32'd0);
        check("rst_addr", im_addr_o, 32'd0);
        check("rst_data", im_data_o, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_reset", {31'd0, rx_ready_o}, 32'd1);
    endtask

    task automatic wait_end(input int max_cycles);
        int i;
        i = 0;
        while (!(done_o || err_o) && i < max_cycles) begin
            @(negedge clk_i);
            i++;
        end
        if (!(done_o || err_o)) check("end_timeout", 32'd0, 32'd1);
    endtask

    int wr_base;

    initial begin
        // Test 1: two words back-to-back.
        do_reset();
        stream = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20};
        model_expect();
        check("t1_model_w0", exp_q[0].data, 32'h20010005);
        check("t1_model_w1", exp_q[1].data, 32'h00221820);
        check("t1_model_a1", exp_q[1].addr, 32'h00000004);
        wr_base = wr_count;
        send_stream(0);
        check("t1_full_rate", 32'(last_xfer_cyc - first_xfer_cyc), 32'd9);
        wait_end(20);
        check("t1_done_latency", 32'(cyc - last_we_cyc), 32'd2);
        check("t1_writes", 32'(wr_count - wr_base), 32'd2);
        check("t1_pending", 32'(exp_q.size()), 32'd0);
        check("t1_cpu_rst_n", {31'd0, cpu_rst_n_o}, 32'd1);
        check("t1_err", {31'd0, err_o}, 32'd0);

        // Test 2: empty program.
        do_reset();
        stream = '{8'h00, 8'h00};
        model_expect();
        wr_base = wr_count;
        send_stream(0);
        wait_end(20);
        check("t2_done_latency", 32'(cyc - last_xfer_cyc), 32'd1);
        check("t2_done", {31'd0, done_o}, 32'd1);
        check("t2_err", {31'd0, err_o}, 32'd0);
        check("t2_writes", 32'(wr_count - wr_base), 32'd0);

        // Test 3: oversize header.
        do_reset();
        stream = '{8'h00, 8'h21};
        model_expect();
        wr_base = wr_count;
        send_stream(0);
        wait_end(20);
        repeat (3) @(negedge clk_i);
        check("t3_err", {31'd0, err_o}, 32'd1);
        check("t3_done", {31'd0, done_o}, 32'd0);
        check("t3_cpu_rst_n", {31'd0, cpu_rst_n_o}, 32'd0);
        check("t3_ready", {31'd0, rx_ready_o}, 32'd0);
        check("t3_writes", 32'(wr_count - wr_base), 32'd0);

        // Test 4: full depth with random valid gaps.
        do_reset();
        stream = '{8'h00, 8'h20};
        for (int i = 0; i < 4*DEPTH; i++) stream.push_back(8'($urandom));
        model_expect();
        wr_base = wr_count;
        send_stream(50);
        wait_end(50);
        check("t4_writes", 32'(wr_count - wr_base), 32'd32);
        check("t4_last_addr", last_addr, 32'h0000007C);
        check("t4_pending", 32'(exp_q.size()), 32'd0);
        check("t4_done", {31'd0, done_o}, 32'd1);

        // Test 5: reset aborts a load, then a fresh stream.
        do_reset();
        stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        wr_base = wr_count;
        send_stream(0);
        do_reset();
        check("t5_abort_writes", 32'(wr_count - wr_base), 32'd0);
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model_expect();
        check("t5_model_w0", exp_q[0].data, 32'hDEADBEEF);
        send_stream(0);
        wait_end(20);
        check("t5_writes", 32'(wr_count - wr_base), 32'd1);
        check("t5_done", {31'd0, done_o}, 32'd1);

        // Test 6: bytes after completion are ignored.
        wr_base = wr_count;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            rx_valid_i = 1'b1;
            rx_data_i = 8'(8'h55 + i);
            check("t6_ready", {31'd0, rx_ready_o}, 32'd0);
            check("t6_addr", im_addr_o, 32'd0);
            check("t6_data", im_data_o, 32'hDEADBEEF);
            check("t6_done", {31'd0, done_o}, 32'd1);
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        check("t6_writes", 32'(wr_count - wr_base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
